phrase_player: RTL
==================

// Module: phrase_player
// PURPOSE
//  Generalised phrase sequencer. Reads one packed phrase-DB entry, then plays it
//  note by note against a tempo tick, emitting one note code per note slot.
//  Adds per-note long/short durations, a triplet mode, rest handling, looping and abort.
//  Sits between the phrase DB and the tone generator.
// PARAMETERS
//  NOTE_W        4   bits per note code in the DB entry
//  MAX_NOTES     8   note slots per entry (DB entry width = NOTE_W*MAX_NOTES)
//  ADDR_W        4   phrase address width
//  SHORT_TICKS   6   ticks for a note whose length bit is 0
//  LONG_TICKS    12  ticks for a note whose length bit is 1
//  TRIPLET_TICKS 4   ticks per note in triplet mode (length bits ignored)
//  REST_CODE     7   note code meaning silence
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  async active-low reset
//  tick         in   1                  tempo pulse, one clk wide
//  start        in   1                  begin phrase (sampled in IDLE only)
//  phrase_addr  in   ADDR_W             phrase to play, latched on start
//  triplet      in   1                  triplet mode, latched on start
//  loop         in   1                  replay phrase after the last note (sampled live)
//  stop         in   1                  abort playback
//  db_addr      out  ADDR_W             address to the DB
//  db_entry     in   NOTE_W*MAX_NOTES   packed notes; note 0 in the MSBs
//  length_entry in   MAX_NOTES          length bits; bit MAX_NOTES-1 belongs to note 0
//  n_note       in   clog2(MAX_NOTES)   note count minus 1
//  note_code    out  NOTE_W             current note code
//  note_valid   out  1                  1 while a non-rest note is sounding
//  note_strobe  out  1                  1-clk pulse on the first cycle of every note slot
//  busy         out  1                  high in FETCH and PLAY
//  done         out  1                  1-clk pulse on return to IDLE
// BEHAVIOUR
//  Reset: state IDLE; every output is 0, including db_addr. Reset is immediate (async)
//   at any point, including mid-phrase.
//  FSM:
//   IDLE  -> FETCH  when start=1; latch phrase_addr into db_addr; latch triplet.
//   FETCH -> PLAY   after exactly 1 cycle; register db_entry, length_entry and n_note;
//                   idx=0; cnt=dur(0).
//   PLAY  -> on entry and on every note advance: note_strobe=1 for 1 cycle;
//             note_code = slot idx; note_valid = (code != REST_CODE).
//   Each tick in PLAY decrements cnt. On the tick where cnt==1:
//     idx < n_note:          idx++, cnt=dur(idx), strobe.
//     idx == n_note, loop=1:  -> FETCH (same db_addr, re-read).
//     idx == n_note, loop=0:  -> IDLE, done=1.
//  dur(i) = TRIPLET_TICKS if triplet; else LONG_TICKS if length bit(i) is 1, else SHORT_TICKS.
//  stop=1 in FETCH or PLAY -> IDLE on the next edge; done=1, note_valid=0. stop has priority
//   over a coincident tick.
//  A tick arriving in the FETCH cycle is dropped. A tick in IDLE has no effect.
//  start while busy is ignored. start and stop in the same IDLE cycle: stop wins, stay IDLE.
//  Phrase length is n_note+1 slots, from 1 to MAX_NOTES. Slots above n_note are never played.
//  cnt width = clog2(max(LONG_TICKS, TRIPLET_TICKS) + 1).
//  note_code holds its value in IDLE. note_valid is 0 in IDLE and FETCH.
// TESTING
//  T1 entry 0x11272020, length 0x80, n_note 6, triplet 0:
//     codes 1,1,2,7,2,0,2; durations 12,6,6,6,6,6,6 ticks;
//     done on tick 48; note_valid=0 during slot 3.
//  T2 entry 0x54632400, n_note 5, triplet 1: codes 5,4,6,3,2,4, each 4 ticks;
//     done on tick 24; length bits ignored.
//  T3 loop=1 with the T1 entry: after tick 48, 1 FETCH cycle, then strobe with code 1;
//     assert stop -> next edge busy=0, done=1, note_valid=0.
//  T4 rst_n low during slot 2 of T1: all outputs 0 without a clock edge;
//     after release, a start replays from slot 0.
//  T5 start pulsed mid-phrase with a different phrase_addr: db_addr unchanged and the
//     sequence is unaffected. A tick in the FETCH cycle does not shorten slot 0.
//  T6 n_note 0, entry 0x3xxxxxxx, length 0x00: single slot, code 3 for 6 ticks, then done.

Source files
------------

// File: rtl/phrase_player.sv
// Phrase sequencer: fetches one packed phrase entry, then steps its note slots on tempo ticks.
// One FETCH cycle per (re)read, registered outputs; no backpressure, progress is paced by i_tick.
module phrase_player #(
  parameter int NOTE_W        = 4,
  parameter int MAX_NOTES     = 8,
  parameter int ADDR_W        = 4,
  parameter int SHORT_TICKS   = 6,
  parameter int LONG_TICKS    = 12,
  parameter int TRIPLET_TICKS = 4,
  parameter int REST_CODE     = 7,
  localparam int ENTRY_W      = NOTE_W * MAX_NOTES,
  localparam int IDX_W        = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1,
  localparam int MAX_TICKS    = (LONG_TICKS > TRIPLET_TICKS) ? LONG_TICKS : TRIPLET_TICKS,
  localparam int CNT_W        = $clog2(MAX_TICKS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_phrase_addr,
  input  logic               i_triplet,
  input  logic               i_loop,
  input  logic               i_stop,
  output logic [ADDR_W-1:0]  o_db_addr,
  input  logic [ENTRY_W-1:0] i_db_entry,
  input  logic [MAX_NOTES-1:0] i_length_entry,
  input  logic [IDX_W-1:0]   i_n_note,
  output logic [NOTE_W-1:0]  o_note_code,
  output logic               o_note_valid,
  output logic               o_note_strobe,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_db_addr;
  logic                 r_triplet;
  logic [ENTRY_W-1:0]   r_entry;
  logic [MAX_NOTES-1:0] r_len;
  logic [IDX_W-1:0]     r_n_note;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [NOTE_W-1:0]    r_note_code;
  logic                 r_note_valid;
  logic                 r_strobe;
  logic                 r_done;

  logic                 w_load, w_fetch_done, w_advance, w_count, w_refetch, w_finish;
  logic [IDX_W-1:0]     w_next_idx;
  logic [NOTE_W-1:0]    w_first_code, w_next_code;

  // Note 0 sits in the MSBs, so shifting left by the slot index brings a slot to the top.
  function automatic logic [NOTE_W-1:0] slot_code(input logic [ENTRY_W-1:0] entry,
                                                  input logic [IDX_W-1:0]   idx);
    logic [ENTRY_W-1:0] shifted;
    shifted = entry << (NOTE_W * int'(idx));
    return shifted[ENTRY_W-1 -: NOTE_W];
  endfunction

  function automatic logic [CNT_W-1:0] slot_dur(input logic [MAX_NOTES-1:0] len,
                                                input logic [IDX_W-1:0]     idx,
                                                input logic                 trip);
    logic [MAX_NOTES-1:0] shifted;
    shifted = len << idx;
    if (trip) return CNT_W'(TRIPLET_TICKS);
    return shifted[MAX_NOTES-1] ? CNT_W'(LONG_TICKS) : CNT_W'(SHORT_TICKS);
  endfunction

  assign w_next_idx   = r_idx + IDX_W'(1);
  assign w_first_code = slot_code(i_db_entry, '0);
  assign w_next_code  = slot_code(r_entry, w_next_idx);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_fetch_done = 1'b0;
    w_advance    = 1'b0;
    w_count      = 1'b0;
    w_refetch    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nxt = FETCH;
          w_load      = 1'b1;
        end
      end
      FETCH: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt  = PLAY;
          w_fetch_done = 1'b1;
        end
      end
      PLAY: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end else if (i_tick) begin
          if (r_cnt != CNT_W'(1)) begin
            w_count = 1'b1;
          end else if (r_idx < r_n_note) begin
            w_advance = 1'b1;
          end else if (i_loop) begin
            w_state_nxt = FETCH;
            w_refetch   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_finish    = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_addr    <= '0;
      r_triplet    <= 1'b0;
      r_entry      <= '0;
      r_len        <= '0;
      r_n_note     <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_note_code  <= '0;
      r_note_valid <= 1'b0;
      r_strobe     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (w_load) begin
        r_db_addr <= i_phrase_addr;
        r_triplet <= i_triplet;
      end
      // The DB answers during FETCH, so slot 0 is decoded straight from the inputs.
      if (w_fetch_done) begin
        r_entry      <= i_db_entry;
        r_len        <= i_length_entry;
        r_n_note     <= i_n_note;
        r_idx        <= '0;
        r_cnt        <= slot_dur(i_length_entry, '0, r_triplet);
        r_note_code  <= w_first_code;
        r_note_valid <= (w_first_code != NOTE_W'(REST_CODE));
        r_strobe     <= 1'b1;
      end
      if (w_advance) begin
        r_idx        <= w_next_idx;
        r_cnt        <= slot_dur(r_len, w_next_idx, r_triplet);
        r_note_code  <= w_next_code;
        r_note_valid <= (w_next_code != NOTE_W'(REST_CODE));
        r_strobe     <= 1'b1;
      end
      if (w_count)   r_cnt        <= r_cnt - CNT_W'(1);
      if (w_refetch) r_note_valid <= 1'b0;
      if (w_finish) begin
        r_note_valid <= 1'b0;
        r_done       <= 1'b1;
      end
    end
  end

  assign o_db_addr     = r_db_addr;
  assign o_note_code   = r_note_code;
  assign o_note_valid  = r_note_valid;
  assign o_note_strobe = r_strobe;
  assign o_done        = r_done;
  assign o_busy        = (r_state != IDLE);

endmodule
